// File: rtl/bbox_pkg.sv
// Shared constants, coordinate/address types and FSM states for the bounding-box scanner.
package bbox_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int PIX_W  = 8;
  localparam int THRESH = 128;
  localparam int CW     = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int AW     = $clog2(NPIX);

  typedef logic [CW-1:0] coord_t;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } bbox_state_t;

  function automatic coord_t cmin(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t cmax(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bbox_if.sv
// Sample bus from the scanner to the min/max tracker, with the running box fed back.
interface bbox_if;
  import bbox_pkg::*;

  logic   valid;
  logic   fg;
  coord_t x;
  coord_t y;
  coord_t x_min;
  coord_t y_min;
  coord_t x_max;
  coord_t y_max;

  modport master (
    output valid, fg, x, y,
    input  x_min, y_min, x_max, y_max
  );

  modport slave (
    input  valid, fg, x, y,
    output x_min, y_min, x_max, y_max
  );

endinterface

// File: rtl/bbox_tracker.sv
// Min/max accumulator: folds every valid foreground coordinate into the running box.
module bbox_tracker
  import bbox_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  bbox_if.slave bus
);

  coord_t x_min_q, x_min_d;
  coord_t y_min_q, y_min_d;
  coord_t x_max_q, x_max_d;
  coord_t y_max_q, y_max_d;

  always_comb begin
    x_min_d = x_min_q;
    y_min_d = y_min_q;
    x_max_d = x_max_q;
    y_max_d = y_max_q;
    if (bus.valid && bus.fg) begin
      x_min_d = cmin(x_min_q, bus.x);
      y_min_d = cmin(y_min_q, bus.y);
      x_max_d = cmax(x_max_q, bus.x);
      y_max_d = cmax(y_max_q, bus.y);
    end
  end

  // Reset leaves min above max, which is how an empty image is recognised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min_q <= coord_t'(IMG_W - 1);
      y_min_q <= coord_t'(IMG_H - 1);
      x_max_q <= '0;
      y_max_q <= '0;
    end else begin
      x_min_q <= x_min_d;
      y_min_q <= y_min_d;
      x_max_q <= x_max_d;
      y_max_q <= y_max_d;
    end
  end

  assign bus.x_min = x_min_q;
  assign bus.y_min = y_min_q;
  assign bus.x_max = x_max_q;
  assign bus.y_max = y_max_q;

endmodule

// File: rtl/bounding_box_top.sv
// Raster-scans the preloaded image RAM once per reset and reports the foreground bounding box.
module bounding_box_top
  import bbox_pkg::*;
(
  input logic       CLOCK_50,
  input logic [3:0] KEY
);

  logic clk;
  logic rst_n;
  logic unused_keys;

  assign clk         = CLOCK_50;
  assign rst_n       = KEY[3];
  assign unused_keys = ^KEY[2:0];

  localparam addr_t  LAST_ADDR = addr_t'(NPIX - 1);
  localparam coord_t X_LAST    = coord_t'(IMG_W - 1);

  // Preloaded externally; the logic only ever reads it.
  logic [PIX_W-1:0] ram [0:IMG_W*IMG_H-1];

  logic   done;
  coord_t xMin, yMin, xMax, yMax;

  bbox_state_t      state_q, state_d;
  addr_t            addr_q;
  coord_t           x_q, y_q;
  coord_t           px_q, py_q;
  logic             pix_valid_q;
  logic [PIX_W-1:0] pix_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = SCAN;
      SCAN:    if (addr_q == LAST_ADDR) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // px_q/py_q travel alongside the read so the coordinate lines up with its pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_valid_q <= (state_q == SCAN);
      if (state_q == SCAN) begin
        px_q   <= x_q;
        py_q   <= y_q;
        addr_q <= addr_q + addr_t'(1);
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + coord_t'(1);
        end else begin
          x_q <= x_q + coord_t'(1);
        end
      end
    end
  end

  // Unreset registered read keeps the array mappable onto block RAM.
  always_ff @(posedge clk) begin
    pix_q <= ram[addr_q];
  end

  bbox_if trk_bus ();

  assign trk_bus.valid = pix_valid_q;
  assign trk_bus.fg    = (pix_q >= PIX_W'(THRESH));
  assign trk_bus.x     = px_q;
  assign trk_bus.y     = py_q;

  bbox_tracker u_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (trk_bus)
  );

  assign done = (state_q == DONE);
  assign xMin = trk_bus.x_min;
  assign yMin = trk_bus.y_min;
  assign xMax = trk_bus.x_max;
  assign yMax = trk_bus.y_max;

endmodule

// File: tb/tb_bounding_box_top.sv
// Bench for bounding_box_top plus a standalone bbox_tracker driven through bbox_if.
module tb_bounding_box_top;
  import bbox_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY;

  always #10 CLOCK_50 = ~CLOCK_50;

  bounding_box_top dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY)
  );

  bbox_if tb_bus ();

  bbox_tracker u_trk (
    .clk   (CLOCK_50),
    .rst_n (KEY[3]),
    .bus   (tb_bus)
  );

  int checks   = 0;
  int failures = 0;
  int cycles;
  int exp_x0, exp_y0, exp_x1, exp_y1;
  logic [PIX_W-1:0] img [NPIX];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_box(input string tag, input int x0, input int y0, input int x1, input int y1);
    check({tag, "_xmin"}, 32'(dut.xMin), 32'(x0));
    check({tag, "_ymin"}, 32'(dut.yMin), 32'(y0));
    check({tag, "_xmax"}, 32'(dut.xMax), 32'(x1));
    check({tag, "_ymax"}, 32'(dut.yMax), 32'(y1));
    $display("scan %s: box=(%0d,%0d)-(%0d,%0d) want=(%0d,%0d)-(%0d,%0d)", tag,
             dut.xMin, dut.yMin, dut.xMax, dut.yMax, x0, y0, x1, y1);
  endtask

  task automatic check_trk(input string tag, input int x0, input int y0, input int x1, input int y1);
    check({tag, "_xmin"}, 32'(tb_bus.x_min), 32'(x0));
    check({tag, "_ymin"}, 32'(tb_bus.y_min), 32'(y0));
    check({tag, "_xmax"}, 32'(tb_bus.x_max), 32'(x1));
    check({tag, "_ymax"}, 32'(tb_bus.y_max), 32'(y1));
    $display("tracker %s: box=(%0d,%0d)-(%0d,%0d)", tag,
             tb_bus.x_min, tb_bus.y_min, tb_bus.x_max, tb_bus.y_max);
  endtask

  task automatic trk_step(input bit v, input bit f, input int x, input int y);
    @(negedge CLOCK_50);
    tb_bus.valid = v;
    tb_bus.fg    = f;
    tb_bus.x     = coord_t'(x);
    tb_bus.y     = coord_t'(y);
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < NPIX; i++) img[i] = '0;
  endtask

  task automatic set_px(input int x, input int y, input int v);
    img[y*IMG_W + x] = PIX_W'(v);
  endtask

  // Reference: the box is just the min/max of coordinates whose pixel meets the threshold.
  task automatic ref_box();
    exp_x0 = IMG_W - 1;
    exp_y0 = IMG_H - 1;
    exp_x1 = 0;
    exp_y1 = 0;
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        if (int'(img[y*IMG_W + x]) >= THRESH) begin
          if (x < exp_x0) exp_x0 = x;
          if (x > exp_x1) exp_x1 = x;
          if (y < exp_y0) exp_y0 = y;
          if (y > exp_y1) exp_y1 = y;
        end
  endtask

  // Short asynchronous pulse between edges; the image is loaded while reset is held.
  task automatic pulse_reset(input string tag);
    @(negedge CLOCK_50);
    #2 KEY[3] = 1'b0;
    #1;
    check({tag, "_rst_done"}, 32'(dut.done), 32'(0));
    check_box({tag, "_rst"}, IMG_W - 1, IMG_H - 1, 0, 0);
    for (int i = 0; i < NPIX; i++) dut.ram[i] = img[i];
    #1 KEY[3] = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    cycles = 0;
    while (dut.done !== 1'b1 && cycles < NPIX + 100) begin
      @(posedge CLOCK_50);
      #1;
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(NPIX + 2));
  endtask

  initial begin
    KEY          = 4'b0101;
    tb_bus.valid = 1'b0;
    tb_bus.fg    = 1'b0;
    tb_bus.x     = '0;
    tb_bus.y     = '0;

    #25;
    check("init_done", 32'(dut.done), 32'(0));
    check_box("init", IMG_W - 1, IMG_H - 1, 0, 0);
    check_trk("trk_init", IMG_W - 1, IMG_H - 1, 0, 0);

    @(negedge CLOCK_50);
    KEY[3] = 1'b1;
    trk_step(1'b1, 1'b1, 5, 9);
    check_trk("trk_single", 5, 9, 5, 9);
    trk_step(1'b0, 1'b1, 0, 0);
    check_trk("trk_invalid", 5, 9, 5, 9);
    trk_step(1'b1, 1'b0, IMG_W - 1, IMG_H - 1);
    check_trk("trk_bg", 5, 9, 5, 9);
    trk_step(1'b1, 1'b1, 0, 0);
    trk_step(1'b1, 1'b1, IMG_W - 1, IMG_H - 1);
    check_trk("trk_corners", 0, 0, IMG_W - 1, IMG_H - 1);
    @(negedge CLOCK_50);
    tb_bus.valid = 1'b0;

    // Square, aborted by a reset partway through, then scanned in full.
    clear_img();
    for (int y = 29; y <= 65; y++)
      for (int x = 28; x <= 79; x++) set_px(x, y, 200);
    set_px(28, 29, THRESH);
    set_px(100, 100, THRESH - 1);
    set_px(10, 120, THRESH - 1);
    pulse_reset("sq_start");
    repeat (5000) @(posedge CLOCK_50);
    #1;
    check("sq_midscan_done", 32'(dut.done), 32'(0));
    pulse_reset("sq_abort");
    wait_done("sq");
    check_box("sq", 28, 29, 79, 65);

    // RAM changes while done is high must not disturb the held result.
    dut.ram[0]        = 8'hFF;
    dut.ram[NPIX - 1] = 8'hFF;
    repeat (10) @(posedge CLOCK_50);
    #1;
    check("sq_hold_done", 32'(dut.done), 32'(1));
    check_box("sq_hold", 28, 29, 79, 65);

    clear_img();
    pulse_reset("empty");
    wait_done("empty");
    check_box("empty", IMG_W - 1, IMG_H - 1, 0, 0);

    // Random sub-threshold background with sparse foreground, two forced boundary hits.
    for (int i = 0; i < NPIX; i++) img[i] = PIX_W'($urandom_range(0, THRESH - 1));
    begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int k = 0; k < n; k++)
        set_px(int'($urandom_range(1, IMG_W - 1)), int'($urandom_range(0, IMG_H - 2)),
               int'($urandom_range(THRESH, 255)));
    end
    set_px(0, int'($urandom_range(0, IMG_H - 1)), THRESH);
    set_px(int'($urandom_range(0, IMG_W - 1)), IMG_H - 1, 255);
    ref_box();
    pulse_reset("rnd");
    wait_done("rnd");
    check_box("rnd", exp_x0, exp_y0, exp_x1, exp_y1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
